// File: rtl/state_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : state_serializer
//  Description : Snapshots a WIDTH-bit hash/PRNG state word on a capture
//                strobe and streams it out as OUT_W-bit words, MSB word
//                first, over a valid/ready handshake. The source register
//                may keep iterating while the snapshot drains.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                capture, state_in - snapshot request and state value
//                out_data/valid/ready/last - output word stream
//                busy              - stream in progress
//                overrun, clr_overrun - sticky dropped-capture flag + clear
//  Revision    : 1.0 - initial release
// ============================================================================
module state_serializer #(
    parameter int WIDTH = 256,
    parameter int OUT_W = 32     // WIDTH must be an integer multiple of OUT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             capture,
    input  logic [WIDTH-1:0] state_in,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam int c_NWORDS = WIDTH / OUT_W;
    localparam int c_CNT_W  = (c_NWORDS > 1) ? $clog2(c_NWORDS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(c_NWORDS - 1);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_SEND = 1'b1;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_overrun;

    logic w_sending;
    logic w_xfer;
    logic w_last;
    logic w_accept;

    assign w_sending = (r_state == c_S_SEND);
    assign w_xfer    = w_sending && out_ready;
    assign w_last    = (r_cnt == c_LAST_IDX);
    // A capture is taken when idle, or when it lands exactly on the final
    // handshake so the next snapshot follows without a bubble.
    assign w_accept  = capture && (!w_sending || (w_xfer && w_last));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_S_IDLE;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shreg <= state_in;
                r_cnt   <= '0;
                r_state <= c_S_SEND;
            end else if (w_xfer) begin
                if (w_last) begin
                    r_state <= c_S_IDLE;
                end else begin
                    r_shreg <= r_shreg << OUT_W;
                    r_cnt   <= r_cnt + 1'b1;
                end
            end

            // Setting has priority over clearing so a drop is never lost.
            if (capture && !w_accept) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign out_data  = r_shreg[WIDTH-1 -: OUT_W];
    assign out_valid = w_sending;
    assign busy      = w_sending;
    assign out_last  = w_sending && w_last;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_state_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_state_serializer
//  Description : Self-checking bench for state_serializer. Two instances
//                share all inputs: A (256/32, eight words) and B (256/256,
//                one word). A word-list reference model predicts outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_state_serializer;

    logic         clk = 1'b0;
    logic         reset;
    logic         capture;
    logic [255:0] state_in;
    logic         out_ready;
    logic         clr_overrun;

    logic [31:0]  a_out_data;
    logic         a_out_valid, a_out_last, a_busy, a_overrun;
    logic [255:0] b_out_data;
    logic         b_out_valid, b_out_last, b_busy, b_overrun;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: per instance, the list of words still to be sent.
    logic [255:0] mw [2][8];
    int           mhead [2];
    int           mcnt  [2];
    bit           mov   [2];

    always #5 clk = ~clk;

    state_serializer #(.WIDTH(256), .OUT_W(32)) u_dut_a (
        .clk(clk), .reset(reset), .capture(capture), .state_in(state_in),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_last(a_out_last), .busy(a_busy), .overrun(a_overrun),
        .clr_overrun(clr_overrun)
    );

    state_serializer #(.WIDTH(256), .OUT_W(256)) u_dut_b (
        .clk(clk), .reset(reset), .capture(capture), .state_in(state_in),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_last(b_out_last), .busy(b_busy), .overrun(b_overrun),
        .clr_overrun(clr_overrun)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step(input int k, input int ow);
        int  nw;
        bit  valid, last, xfer, acc;
        nw    = 256 / ow;
        valid = (mcnt[k] != 0);
        last  = (mcnt[k] == 1);
        xfer  = valid && out_ready;
        if (reset) begin
            mcnt[k]  = 0;
            mhead[k] = 0;
            mov[k]   = 1'b0;
        end else begin
            acc = capture && (!valid || (xfer && last));
            if (xfer) begin
                mhead[k]++;
                mcnt[k]--;
            end
            if (acc) begin
                for (int i = 0; i < nw; i++)
                    mw[k][i] = (state_in << (ow * i)) >> (256 - ow);
                mhead[k] = 0;
                mcnt[k]  = nw;
            end
            if (capture && !acc) mov[k] = 1'b1;
            else if (clr_overrun) mov[k] = 1'b0;
        end
    endtask

    task automatic check_outputs;
        chk("a_valid",   a_out_valid, mcnt[0] != 0);
        chk("a_busy",    a_busy,      mcnt[0] != 0);
        chk("a_last",    a_out_last,  mcnt[0] == 1);
        chk("a_overrun", a_overrun,   mov[0]);
        if (mcnt[0] != 0) chk("a_data", a_out_data, mw[0][mhead[0]]);
        chk("b_valid",   b_out_valid, mcnt[1] != 0);
        chk("b_busy",    b_busy,      mcnt[1] != 0);
        chk("b_last",    b_out_last,  mcnt[1] == 1);
        chk("b_overrun", b_overrun,   mov[1]);
        if (mcnt[1] != 0) chk("b_data", b_out_data, mw[1][mhead[1]]);
    endtask

    // Inputs are applied between negedge and posedge; outputs sampled at negedge.
    task automatic tick;
        @(posedge clk);
        model_step(0, 32);
        model_step(1, 256);
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    logic [255:0] st6;

    initial begin
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0; mhead[k] = 0; mov[k] = 1'b0;
        end
        reset = 1'b1; capture = 1'b0; state_in = '0;
        out_ready = 1'b0; clr_overrun = 1'b0;
        tick(); tick();
        chk("rst_a_data", a_out_data, 256'h0);
        chk("rst_b_data", b_out_data, 256'h0);
        reset = 1'b0;
        tick();

        // Basic stream
        state_in = {32'hFFFF0000, 224'h0};
        capture = 1'b1; out_ready = 1'b1;
        tick();
        capture = 1'b0;
        chk("t1_first", a_out_data, 256'hFFFF0000);
        repeat (8) tick();
        chk("t1_idle_valid", a_out_valid, 1'b0);
        chk("t1_idle_busy",  a_busy,      1'b0);

        // Backpressure on word 2
        state_in = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                    32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        capture = 1'b1;
        tick();
        capture = 1'b0;
        tick();
        chk("t2_w2", a_out_data, 256'h22222222);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold", a_out_data, 256'h22222222);
        end
        out_ready = 1'b1;
        tick();
        chk("t2_w3", a_out_data, 256'h33333333);
        repeat (7) tick();

        // Overrun: capture during word 3
        state_in = rand256();
        capture = 1'b1;
        tick();
        capture = 1'b0;
        tick(); tick();
        state_in = rand256();
        capture = 1'b1;
        tick();
        capture = 1'b0;
        chk("t3_ovr_set", a_overrun, 1'b1);
        repeat (8) tick();
        chk("t3_ovr_sticky", a_overrun, 1'b1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("t3_ovr_clr", a_overrun, 1'b0);

        // Back-to-back capture on the last handshake
        state_in = rand256();
        capture = 1'b1;
        tick();
        capture = 1'b0;
        repeat (7) tick();
        chk("t4_on_last", a_out_last, 1'b1);
        state_in = {256{1'b1}};
        capture = 1'b1;
        tick();
        capture = 1'b0;
        chk("t4_valid", a_out_valid, 1'b1);
        chk("t4_data",  a_out_data,  256'hFFFFFFFF);
        chk("t4_last",  a_out_last,  1'b0);
        chk("t4_ovr",   a_overrun,   1'b0);
        repeat (8) tick();

        // Reset mid-stream during word 4
        state_in = rand256();
        capture = 1'b1;
        tick();
        capture = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_valid", a_out_valid, 1'b0);
        chk("t5_busy",  a_busy,      1'b0);
        chk("t5_data",  a_out_data,  256'h0);
        state_in = {32'hCAFEF00D, 224'h0};
        capture = 1'b1;
        tick();
        capture = 1'b0;
        chk("t5_restart", a_out_data, 256'hCAFEF00D);
        repeat (10) tick();

        // Single-word instance
        st6 = rand256();
        state_in = st6;
        capture = 1'b1;
        tick();
        capture = 1'b0; out_ready = 1'b0;
        tick();
        chk("t6_data", b_out_data, st6);
        chk("t6_last", b_out_last, 1'b1);
        out_ready = 1'b1;
        tick();
        chk("t6_idle", b_out_valid, 1'b0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 199) == 0);
            capture     = ($urandom_range(0, 5) == 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            clr_overrun = ($urandom_range(0, 9) == 0);
            state_in    = rand256();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
